clkspec_v2arb_rr_server: RTL and testbench
==========================================

// Module: clkspec_v2arb_rr_server
// PURPOSE
//  Round-robin arbiter/sequencer for one shared 4-bit arithmetic resource among NCLIENT requesters.
//  Each client holds req with its operands until acked.
//  The block grants one client and forwards its a/b to the resource with a start pulse.
//  It waits for done (with timeout), then returns the result with a one-cycle per-client ack.
//  Sits between the client array and the shared operator in the arbitration testbench.
// PARAMETERS
//  NCLIENT  4   number of requesters (2..8)
//  WIDTH    4   operand/result width
//  TIMEOUT  15  max WAIT cycles for res_done before abort (>=2)
// PORTS
//  clk        in   1              clock, rising edge
//  reset      in   1              asynchronous, active-low
//  req        in   NCLIENT        request per client; held until matching ack
//  a_in       in   NCLIENT*WIDTH  operand A, client i at [i*WIDTH +: WIDTH]
//  b_in       in   NCLIENT*WIDTH  operand B, same packing
//  ack        out  NCLIENT        one-hot, 1-cycle result-valid to granted client
//  y_out      out  WIDTH          result; valid only while ack != 0
//  err        out  1              with ack: 1 = resource timed out, y_out = 0
//  res_a      out  WIDTH          operand A to shared resource
//  res_b      out  WIDTH          operand B to shared resource
//  res_start  out  1              1-cycle start pulse to resource
//  res_done   in   1              resource result valid (sampled in WAIT only)
//  res_y      in   WIDTH          resource result
//  busy       out  1              1 whenever state != IDLE
//  grant_id   out  3              index of current/last granted client
// BEHAVIOUR
//  Reset (reset==0, async):
//   - state=IDLE, ptr=0, grant_id=0, timer=0.
//   - areg=breg=yreg=0, errreg=0.
//   - Outputs: ack=0, res_start=0, busy=0, y_out=0, err=0, res_a=res_b=0.
//  FSM, one state per cycle except WAIT:
//   IDLE   -> ISSUE when |req; otherwise stay.
//          Winner = first i with req[i]=1 scanning ptr, ptr+1, ... mod NCLIENT.
//          On exit: areg/breg <= winner's a_in/b_in; grant_id <= winner.
//   ISSUE  res_start=1; res_a=areg, res_b=breg (held through WAIT); timer<=0; -> WAIT.
//   WAIT   res_done=1: yreg<=res_y, errreg<=0, -> RETURN.
//          else if timer==TIMEOUT-1: yreg<=0, errreg<=1, -> RETURN.
//          else timer<=timer+1.
//   RETURN ack[grant_id]=1, y_out=yreg, err=errreg.
//          ptr <= (grant_id==NCLIENT-1) ? 0 : grant_id+1; -> IDLE.
//  Output decode:
//   - ack/res_start/busy decoded from registered state: glitch-free, no combinational path from req.
//   - y_out and err forced to 0 outside RETURN.
//  Latency: req seen in IDLE -> res_start 1 cycle later -> ack at done-cycle+1.
//   Minimum req->ack is 4 cycles (res_done in first WAIT cycle).
//  Handshake and priority:
//   - Client drops req on the edge that samples its ack, so IDLE never re-grants the same request.
//   - Even if req is still high, rotated ptr gives every other pending client priority first.
//   - A req rising during ISSUE/WAIT/RETURN is not lost; it is considered at the next IDLE.
//   - Operands are latched at grant; later a_in/b_in changes do not affect the in-flight op.
//   - res_done outside WAIT is ignored.
//   - res_done and timeout in the same cycle: done wins, err=0.
//   - Reset mid-operation aborts immediately; no ack is issued for the aborted request.
//   - Fairness: with all req high, grants cycle 0,1,..,NCLIENT-1,0 with no starvation.
// TESTING
//  1 Reset: reset=0 with req=4'b1111 -> ack=0, res_start=0, busy=0; after release, first grant is client 0.
//  2 Single: req[2]=1, a=3, b=5; resource returns y=8 one cycle after start
//    -> res_a=3, res_b=5, ack=4'b0100, y_out=8, err=0, 4 cycles after req.
//  3 Round-robin: req=4'b1111 held, re-raised after each ack -> grant_id order 0,1,2,3,0; each ack one-hot.
//  4 Rotation skip: after client 1 served, req=4'b0011 -> client 0 granted next, then client 1.
//  5 Timeout: req[3]=1, res_done never asserted -> ack=4'b1000, err=1, y_out=0 after TIMEOUT WAIT cycles.
//    res_done arriving in the final WAIT cycle -> err=0 with the real y.
//  6 Reset mid-WAIT: reset pulsed low while in WAIT for client 1 -> no ack; state IDLE, ptr=0.
//    Pending req[1] is re-granted after release.

Source files
------------

// File: rtl/clkspec_v2arb_rr_server_if.sv
// Bundle between the client array / shared operator and the round-robin server.
// The "master" side is the environment (clients and resource); "slave" is the server.
interface clkspec_v2arb_rr_server_if #(
  parameter int NCLIENT = 4,
  parameter int WIDTH   = 4
);
  logic [NCLIENT-1:0]       req;
  logic [NCLIENT*WIDTH-1:0] a_in;
  logic [NCLIENT*WIDTH-1:0] b_in;
  logic [NCLIENT-1:0]       ack;
  logic [WIDTH-1:0]         y_out;
  logic                     err;
  logic [WIDTH-1:0]         res_a;
  logic [WIDTH-1:0]         res_b;
  logic                     res_start;
  logic                     res_done;
  logic [WIDTH-1:0]         res_y;
  logic                     busy;
  logic [2:0]               grant_id;

  modport master (
    output req, a_in, b_in, res_done, res_y,
    input  ack, y_out, err, res_a, res_b, res_start, busy, grant_id
  );

  modport slave (
    input  req, a_in, b_in, res_done, res_y,
    output ack, y_out, err, res_a, res_b, res_start, busy, grant_id
  );
endinterface

// File: rtl/clkspec_v2arb_rr_server.sv
// Round-robin sequencer sharing one arithmetic resource among NCLIENT requesters:
// grant, issue with start pulse, wait for done (bounded), return result with one-cycle ack.
module clkspec_v2arb_rr_server #(
  parameter int NCLIENT = 4,
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  clkspec_v2arb_rr_server_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RETURN = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [2:0]         ptr_r;
  logic [2:0]         grant_r;
  logic [TW-1:0]      timer_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   y_r;
  logic               err_r;

  logic [7:0]         req_ext_s;
  logic [3:0]         idx_s;
  logic               hit_s;
  logic               any_s;
  logic [2:0]         win_s;
  logic [WIDTH-1:0]   a_win_s;
  logic [WIDTH-1:0]   b_win_s;
  logic               timeout_s;
  logic [NCLIENT-1:0] ack_s;

  assign timeout_s = (timer_r == TW'(TIMEOUT - 1));

  // Rotating-priority winner search starting at ptr, plus the winner's operands.
  always_comb begin
    req_ext_s = 8'(bus.req);
    idx_s     = 4'd0;
    hit_s     = 1'b0;
    any_s     = 1'b0;
    win_s     = 3'd0;
    a_win_s   = {WIDTH{1'b0}};
    b_win_s   = {WIDTH{1'b0}};
    for (int k = 0; k < NCLIENT; k++) begin
      idx_s = {1'b0, ptr_r} + 4'(k);
      idx_s = (idx_s >= 4'(NCLIENT)) ? (idx_s - 4'(NCLIENT)) : idx_s;
      hit_s = req_ext_s[idx_s[2:0]] & ~any_s;
      win_s = hit_s ? idx_s[2:0] : win_s;
      any_s = any_s | hit_s;
    end
    for (int i = 0; i < NCLIENT; i++) begin
      a_win_s = (win_s == 3'(i)) ? bus.a_in[i*WIDTH +: WIDTH] : a_win_s;
      b_win_s = (win_s == 3'(i)) ? bus.b_in[i*WIDTH +: WIDTH] : b_win_s;
    end
  end

  // Next-state logic; done takes precedence over the timeout abort.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:   state_s = any_s ? ST_ISSUE : ST_IDLE;
      ST_ISSUE:  state_s = ST_WAIT;
      ST_WAIT:   state_s = (bus.res_done || timeout_s) ? ST_RETURN : ST_WAIT;
      ST_RETURN: state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand latch at grant, wait timer, result capture and pointer rotation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_r   <= 3'd0;
      grant_r <= 3'd0;
      timer_r <= {TW{1'b0}};
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      y_r     <= {WIDTH{1'b0}};
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_s) begin
            a_r     <= a_win_s;
            b_r     <= b_win_s;
            grant_r <= win_s;
          end
        end
        ST_ISSUE: timer_r <= {TW{1'b0}};
        ST_WAIT: begin
          if (bus.res_done) begin
            y_r   <= bus.res_y;
            err_r <= 1'b0;
          end else if (timeout_s) begin
            y_r   <= {WIDTH{1'b0}};
            err_r <= 1'b1;
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
        ST_RETURN: ptr_r <= (grant_r == 3'(NCLIENT - 1)) ? 3'd0 : (grant_r + 3'd1);
        default: ;
      endcase
    end
  end

  // One-hot ack decoded purely from registered state.
  always_comb begin
    ack_s = {NCLIENT{1'b0}};
    for (int i = 0; i < NCLIENT; i++) begin
      ack_s[i] = (state_r == ST_RETURN) && (grant_r == 3'(i));
    end
  end

  assign bus.ack       = ack_s;
  assign bus.res_start = (state_r == ST_ISSUE);
  assign bus.busy      = (state_r != ST_IDLE);
  assign bus.y_out     = (state_r == ST_RETURN) ? y_r : {WIDTH{1'b0}};
  assign bus.err       = (state_r == ST_RETURN) ? err_r : 1'b0;
  assign bus.res_a     = a_r;
  assign bus.res_b     = b_r;
  assign bus.grant_id  = grant_r;

endmodule

// File: tb/tb_clkspec_v2arb_rr_server.sv
// Bench for clkspec_v2arb_rr_server: directed scenarios with literal expectations,
// then random clients/resource checked every cycle against a transaction-level model.
module tb_clkspec_v2arb_rr_server;
  localparam int N  = 4;
  localparam int W  = 4;
  localparam int TO = 15;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  clkspec_v2arb_rr_server_if #(.NCLIENT(N), .WIDTH(W)) bus ();

  clkspec_v2arb_rr_server #(.NCLIENT(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: age counts cycles since grant (1 = start cycle, k+1 = k-th wait cycle).
  int         m_age = 0;
  bit         m_ret = 1'b0;
  int         m_cli = 0;
  int         m_ptr = 0;
  logic [W-1:0] m_a = '0, m_b = '0, m_y = '0;
  bit         m_err = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_age = 0; m_ret = 0; m_cli = 0; m_ptr = 0;
      m_a = '0; m_b = '0; m_y = '0; m_err = 0;
    end else if (m_ret) begin
      m_ptr = (m_cli + 1) % N;
      m_age = 0;
      m_ret = 0;
    end else if (m_age == 0) begin
      bit found;
      found = 0;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (!found && bus.req[j]) begin
          found = 1;
          m_cli = j;
          m_a   = bus.a_in[j*W +: W];
          m_b   = bus.b_in[j*W +: W];
          m_age = 1;
        end
      end
    end else if (m_age == 1) begin
      m_age = 2;
    end else if (bus.res_done) begin
      m_y = bus.res_y; m_err = 0; m_ret = 1;
    end else if (m_age - 1 == TO) begin
      m_y = '0; m_err = 1; m_ret = 1;
    end else begin
      m_age++;
    end
  end

  always @(negedge clk) begin
    chk("busy",      32'(bus.busy),      32'(m_age != 0));
    chk("res_start", 32'(bus.res_start), 32'(m_age == 1));
    chk("ack",       32'(bus.ack),       m_ret ? (32'd1 << m_cli) : 32'd0);
    chk("y_out",     32'(bus.y_out),     m_ret ? 32'(m_y) : 32'd0);
    chk("err",       32'(bus.err),       m_ret ? 32'(m_err) : 32'd0);
    chk("res_a",     32'(bus.res_a),     32'(m_a));
    chk("res_b",     32'(bus.res_b),     32'(m_b));
    chk("grant_id",  32'(bus.grant_id),  32'(m_cli));
  end

  // Environment behaviour: auto = random clients, rearm = clients keep req after ack.
  bit auto_mode = 0;
  bit rearm     = 0;
  int fix_lat   = 1;
  int res_cnt   = 0;

  task automatic step();
    @(posedge clk);
    #2;
    bus.res_done = 1'b0;
    if (bus.res_start) begin
      res_cnt = (fix_lat > 0) ? fix_lat : int'($urandom_range(1, TO + 1));
    end else if (res_cnt > 0) begin
      res_cnt--;
      if (res_cnt == 0) begin
        bus.res_done = 1'b1;
        bus.res_y    = bus.res_a + bus.res_b;
      end
    end else if (auto_mode && !bus.busy && $urandom_range(0, 5) == 0) begin
      bus.res_done = 1'b1;
      bus.res_y    = W'($urandom);
    end
    for (int i = 0; i < N; i++) begin
      if (bus.ack[i] && !rearm) begin
        bus.req[i] = 1'b0;
      end else if (auto_mode && !bus.req[i] && $urandom_range(0, 3) == 0) begin
        bus.req[i]          = 1'b1;
        bus.a_in[i*W +: W]  = W'($urandom);
        bus.b_in[i*W +: W]  = W'($urandom);
      end
      if (auto_mode && $urandom_range(0, 7) == 0) bus.a_in[i*W +: W] = W'($urandom);
    end
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (bus.ack == '0 && n < 60);
    chk("ack_within_bound", 32'(bus.ack != '0), 32'd1);
  endtask

  int n;
  int order [5] = '{0, 1, 2, 3, 0};

  initial begin
    bus.req = '0; bus.a_in = '0; bus.b_in = '0; bus.res_done = 1'b0; bus.res_y = '0;
    bus.req = 4'b1111;
    #1 reset = 1'b0;
    #11;
    chk("rst_ack",   32'(bus.ack),       32'd0);
    chk("rst_start", 32'(bus.res_start), 32'd0);
    chk("rst_busy",  32'(bus.busy),      32'd0);
    step();
    reset = 1'b1;
    step();
    chk("first_start", 32'(bus.res_start), 32'd1);
    chk("first_grant", 32'(bus.grant_id),  32'd0);

    rearm = 1;
    for (int k = 0; k < 5; k++) begin
      wait_ack(n);
      chk("rr_order", 32'(bus.grant_id), 32'(order[k]));
      chk("rr_onehot", 32'($onehot(bus.ack)), 32'd1);
    end
    bus.req = '0;
    rearm   = 0;

    step();
    bus.req = 4'b0100;
    bus.a_in[2*W +: W] = 4'd3;
    bus.b_in[2*W +: W] = 4'd5;
    step();
    chk("single_start", 32'(bus.res_start), 32'd1);
    chk("single_res_a", 32'(bus.res_a),     32'd3);
    chk("single_res_b", 32'(bus.res_b),     32'd5);
    step();
    step();
    chk("single_ack",  32'(bus.ack),   32'b0100);
    chk("single_y",    32'(bus.y_out), 32'd8);
    chk("single_err",  32'(bus.err),   32'd0);

    step();
    bus.req = 4'b0010;
    wait_ack(n);
    chk("rot_c1", 32'(bus.grant_id), 32'd1);
    step();
    bus.req = 4'b0011;
    wait_ack(n);
    chk("rot_first", 32'(bus.ack), 32'b0001);
    wait_ack(n);
    chk("rot_second", 32'(bus.ack), 32'b0010);

    step();
    fix_lat = 100;
    bus.req = 4'b1000;
    bus.a_in[3*W +: W] = 4'd7;
    bus.b_in[3*W +: W] = 4'd6;
    wait_ack(n);
    chk("to_latency", 32'(n),         32'(TO + 2));
    chk("to_ack",     32'(bus.ack),   32'b1000);
    chk("to_err",     32'(bus.err),   32'd1);
    chk("to_y",       32'(bus.y_out), 32'd0);
    step();
    fix_lat = TO;
    bus.req = 4'b1000;
    wait_ack(n);
    chk("late_latency", 32'(n),         32'(TO + 2));
    chk("late_err",     32'(bus.err),   32'd0);
    chk("late_y",       32'(bus.y_out), 32'd13);

    step();
    fix_lat = 100;
    bus.req = 4'b0010;
    step(); step(); step();
    chk("mid_busy", 32'(bus.busy), 32'd1);
    reset   = 1'b0;
    res_cnt = 0;
    #1;
    chk("abort_ack",  32'(bus.ack),  32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    step();
    reset   = 1'b1;
    fix_lat = 1;
    wait_ack(n);
    chk("regrant", 32'(bus.ack), 32'b0010);

    auto_mode = 1;
    fix_lat   = 0;
    for (int c = 0; c < 3000; c++) begin
      step();
      if ($urandom_range(0, 299) == 0) begin
        reset   = 1'b0;
        res_cnt = 0;
        step();
        reset   = 1'b1;
      end
    end
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
